// File: rtl/aes_dec_ctrl.sv
// aes_dec_ctrl: iterative AES inverse cipher. One inverse round is computed
// per clock. Round keys come combinationally from an external key store
// addressed by rk_addr. The plaintext is held in DONE until it is consumed.
module aes_dec_ctrl #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [127:0] in_data,
   output logic         in_ready,
   output logic [3:0]   rk_addr,
   input  logic [127:0] rk_data,
   output logic         out_valid,
   output logic [127:0] out_data,
   input  logic         out_ready,
   output logic         busy
);

   localparam logic [3:0] LAST_RK = 4'(NR);

   // FIPS-197 inverse S-box; entry 0 is in the most significant byte
   localparam logic [0:255][7:0] ISBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t       fsm, fsm_nxt;
   logic [127:0] st, st_nxt;
   logic [3:0]   rnd, rnd_nxt;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a small constant (at most 4 bits) in GF(2^8), poly 0x11B
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 4; i++) begin
         if (c[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] inv_mix(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
              gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
              gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
              gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
   endfunction

   // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns unless last
   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
      logic [127:0] t;
      logic [127:0] m;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            // row r is rotated right by r columns
            t[127-8*(4*c+r) -: 8] = ISBOX[s[127-8*(4*((c+4-r)%4)+r) -: 8]];
         end
      end
      t = t ^ k;
      for (int c = 0; c < 4; c++) begin
         m[127-32*c -: 32] = inv_mix(t[127-32*c -: 32]);
      end
      return last ? t : m;
   endfunction

   // State register, round counter and FSM state; reset clears everything
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm <= IDLE;
         st  <= '0;
         rnd <= '0;
      end else begin
         fsm <= fsm_nxt;
         st  <= st_nxt;
         rnd <= rnd_nxt;
      end
   end

   // Next-state logic, round-key addressing and handshake outputs
   always_comb begin
      fsm_nxt   = fsm;
      st_nxt    = st;
      rnd_nxt   = rnd;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      rk_addr   = 4'd0;
      case (fsm)
         IDLE: begin
            in_ready = 1'b1;
            rk_addr  = LAST_RK;
            if (in_valid) begin
               st_nxt  = in_data ^ rk_data;
               rnd_nxt = LAST_RK - 4'd1;
               fsm_nxt = RUN;
            end
         end
         RUN: begin
            busy    = 1'b1;
            rk_addr = rnd;
            st_nxt  = inv_round(st, rk_data, rnd == 4'd0);
            // leaving at rnd==0 means the counter never wraps
            if (rnd == 4'd0) fsm_nxt = DONE;
            else             rnd_nxt = rnd - 4'd1;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) fsm_nxt = IDLE;
         end
         default: fsm_nxt = IDLE;
      endcase
   end

   assign out_data = st;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// tb_aes_dec_ctrl: scoreboard bench for aes_dec_ctrl, NR=10 and NR=14 builds.
// Expected plaintexts come from FIPS-197 vectors or from a forward-cipher
// reference model (ciphertext = encrypt(random plaintext)).
module tb_aes_dec_ctrl;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         iv0, ir0, ov0, or0, bz0;
   logic         iv1, ir1, ov1, or1, bz1;
   logic [127:0] id0, rd0, od0, ep0;
   logic [127:0] id1, rd1, od1, ep1;
   logic [3:0]   ra0, ra1;

   logic [127:0] ks0 [16];
   logic [127:0] ks1 [16];
   logic [7:0]   sb  [256];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic bp_rand = 1'b0;
   logic seen0 = 1'b0, seen1 = 1'b0;
   logic [127:0] q0 [$];
   logic [127:0] q1 [$];
   int   t0 [$];
   int   t1 [$];

   assign rd0 = ks0[ra0];
   assign rd1 = ks1[ra1];

   aes_dec_ctrl #(.NR(10)) d10 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_data(id0), .in_ready(ir0),
      .rk_addr(ra0), .rk_data(rd0), .out_valid(ov0), .out_data(od0),
      .out_ready(or0), .busy(bz0));

   aes_dec_ctrl #(.NR(14)) d14 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
      .rk_addr(ra1), .rk_data(rd1), .out_valid(ov1), .out_data(od1),
      .out_ready(or1), .busy(bz1));

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chkv(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got no event within bound, expected event", name);
   endtask

   // ---------------- reference model (forward cipher) ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, a;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         a = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sb[x] = a;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   // Key expansion; key is left-aligned in 256 bits; g selects the store
   task automatic expand(input logic [255:0] key, input int nr, input int g);
      logic [31:0] w [60];
      logic [31:0] tmp;
      logic [7:0]  rc;
      int nk;
      nk = nr - 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            tmp = subw(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      for (int k = 0; k <= nr; k++) begin
         if (g == 0) ks0[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
         else        ks1[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
      end
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt, input int g);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] k;
      logic [127:0] res;
      int nr;
      nr = (g == 0) ? 10 : 14;
      k  = (g == 0) ? ks0[0] : ks1[0];
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
      for (int rd = 1; rd <= nr; rd++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
         if (rd < nr) begin
            for (int c = 0; c < 4; c++) begin
               t[0] = s[4*c]; t[1] = s[4*c+1]; t[2] = s[4*c+2]; t[3] = s[4*c+3];
               s[4*c]   = gmul(t[0], 8'h02) ^ gmul(t[1], 8'h03) ^ t[2] ^ t[3];
               s[4*c+1] = t[0] ^ gmul(t[1], 8'h02) ^ gmul(t[2], 8'h03) ^ t[3];
               s[4*c+2] = t[0] ^ t[1] ^ gmul(t[2], 8'h02) ^ gmul(t[3], 8'h03);
               s[4*c+3] = gmul(t[0], 8'h03) ^ t[1] ^ t[2] ^ gmul(t[3], 8'h02);
            end
         end
         k = (g == 0) ? ks0[rd] : ks1[rd];
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // ---------------- scoreboard monitor ----------------
   // Accepts are recorded on the negedge before the accepting edge; outputs
   // are compared every cycle they are presented, popped when consumed.
   always @(negedge clk) begin
      if (rst) begin
         q0.delete(); t0.delete(); seen0 <= 1'b0;
         q1.delete(); t1.delete(); seen1 <= 1'b0;
      end else begin
         if (iv0 && ir0) begin q0.push_back(ep0); t0.push_back(cyc); end
         if (iv1 && ir1) begin q1.push_back(ep1); t1.push_back(cyc); end
         if (ov0) begin
            if (q0.size() == 0) fail("nr10_unexpected_out_valid");
            else begin
               // accept edge counts as edge 1; out_valid follows edge NR+1
               if (!seen0) chkv("nr10_latency", cyc - t0[0], 11);
               seen0 <= 1'b1;
               chk("nr10_plaintext", od0, q0[0]);
               if (or0) begin
                  void'(q0.pop_front()); void'(t0.pop_front()); seen0 <= 1'b0;
               end
            end
         end
         if (ov1) begin
            if (q1.size() == 0) fail("nr14_unexpected_out_valid");
            else begin
               if (!seen1) chkv("nr14_latency", cyc - t1[0], 15);
               seen1 <= 1'b1;
               chk("nr14_plaintext", od1, q1[0]);
               if (or1) begin
                  void'(q1.pop_front()); void'(t1.pop_front()); seen1 <= 1'b0;
               end
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (bp_rand) begin
         or0 = 1'($urandom_range(0, 1));
         or1 = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic send(input int g, input logic [127:0] ct, input logic [127:0] pt);
      int n;
      n = 0;
      if (g == 0) begin iv0 = 1'b1; id0 = ct; ep0 = pt; end
      else        begin iv1 = 1'b1; id1 = ct; ep1 = pt; end
      while (((g == 0) ? ir0 : ir1) !== 1'b1) begin
         n++;
         if (n > 300) begin fail("send_wait_in_ready"); break; end
         tick();
      end
      tick();
      if (g == 0) iv0 = 1'b0;
      else        iv1 = 1'b0;
   endtask

   task automatic wait_idle(input int g);
      int n;
      n = 0;
      while ((g == 0) ? (q0.size() != 0 || bz0) : (q1.size() != 0 || bz1)) begin
         n++;
         if (n > 300) begin fail("wait_idle"); break; end
         tick();
      end
   endtask

   function automatic logic [127:0] r128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time bound reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, n;
      logic [127:0] pt, ct;
      logic [255:0] key;
      rst = 1'b1;
      iv0 = 1'b0; id0 = '0; ep0 = '0; or0 = 1'b1;
      iv1 = 1'b0; id1 = '0; ep1 = '0; or1 = 1'b1;
      build_sbox();
      expand({C1_KEY, 128'h0}, 10, 0);
      expand(C3_KEY, 14, 1);
      tick(); tick(); tick();
      rst = 1'b0;

      // reset state
      chkv("rst_out_valid", 32'(ov0), 0);
      chkv("rst_busy", 32'(bz0), 0);
      chkv("rst_in_ready", 32'(ir0), 1);
      chkv("rst_rk_addr10", 32'(ra0), 10);
      chkv("rst_rk_addr14", 32'(ra1), 14);
      chk("rst_out_data", od0, 128'h0);

      // FIPS-197 C.1
      send(0, C1_CT, C1_PT);
      wait_idle(0);

      // FIPS-197 App. B with per-cycle round-key addressing
      expand({B_KEY, 128'h0}, 10, 0);
      iv0 = 1'b1; id0 = B_CT; ep0 = B_PT;
      chkv("appb_rk_addr_idle", 32'(ra0), 10);
      chkv("appb_in_ready_idle", 32'(ir0), 1);
      tick();
      iv0 = 1'b0;
      for (int k = 9; k >= 0; k--) begin
         chkv("appb_rk_addr_run", 32'(ra0), k);
         chkv("appb_in_ready_run", 32'(ir0), 0);
         chkv("appb_busy_run", 32'(bz0), 1);
         tick();
      end
      chkv("appb_out_valid", 32'(ov0), 1);
      chkv("appb_rk_addr_done", 32'(ra0), 0);
      wait_idle(0);

      // backpressure for 20 cycles in DONE
      expand({C1_KEY, 128'h0}, 10, 0);
      or0 = 1'b0;
      send(0, C1_CT, C1_PT);
      n = 0;
      while (ov0 !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) fail("bp_wait_out_valid");
      for (int i = 0; i < 20; i++) begin
         chkv("bp_out_valid", 32'(ov0), 1);
         chkv("bp_in_ready", 32'(ir0), 0);
         chk("bp_out_data", od0, C1_PT);
         tick();
      end
      or0 = 1'b1;
      wait_idle(0);

      // reset mid-RUN at rnd=5, then a clean C.1 block
      iv0 = 1'b1; id0 = C1_CT; ep0 = C1_PT;
      tick();
      iv0 = 1'b0;
      tick(); tick(); tick(); tick();
      chkv("abort_rk_addr", 32'(ra0), 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chkv("abort_out_valid", 32'(ov0), 0);
      chkv("abort_in_ready", 32'(ir0), 1);
      chkv("abort_busy", 32'(bz0), 0);
      send(0, C1_CT, C1_PT);
      wait_idle(0);

      // in_valid held high across two blocks (C.1 then App. B)
      iv0 = 1'b1; id0 = C1_CT; ep0 = C1_PT;
      chkv("held_in_ready1", 32'(ir0), 1);
      a1 = cyc;
      tick();
      id0 = B_CT; ep0 = B_PT;
      n = 0;
      while (ov0 !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) fail("held_wait_out_valid");
      tick();
      expand({B_KEY, 128'h0}, 10, 0);
      chkv("held_in_ready2", 32'(ir0), 1);
      a2 = cyc;
      chkv("held_accept_interval", a2 - a1, 12);
      tick();
      iv0 = 1'b0;
      wait_idle(0);

      // randomized blocks with random backpressure
      bp_rand = 1'b1;
      for (int b = 0; b < 3; b++) begin
         wait_idle(0);
         expand({r128(), 128'h0}, 10, 0);
         for (int j = 0; j < 4; j++) begin
            pt = r128();
            ct = encrypt(pt, 0);
            send(0, ct, pt);
         end
      end
      bp_rand = 1'b0;
      or0 = 1'b1; or1 = 1'b1;
      wait_idle(0);

      // NR=14: FIPS-197 C.3, then a random key/block
      send(1, C3_CT, C1_PT);
      wait_idle(1);
      key = {r128(), r128()};
      expand(key, 14, 1);
      pt = r128();
      ct = encrypt(pt, 1);
      send(1, ct, pt);
      wait_idle(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
